// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared lamp encodings, state codes and phase width for traffic_light_ctrl
package tl_pkg;

  localparam int PHASE_W = 3;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  localparam logic [PHASE_W-1:0] S_MAIN_GRN = 3'd0;
  localparam logic [PHASE_W-1:0] S_MAIN_YEL = 3'd1;
  localparam logic [PHASE_W-1:0] S_RED1     = 3'd2;
  localparam logic [PHASE_W-1:0] S_SIDE_GRN = 3'd3;
  localparam logic [PHASE_W-1:0] S_SIDE_YEL = 3'd4;
  localparam logic [PHASE_W-1:0] S_RED2     = 3'd5;

  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
  } lamps_t;

  // Unknown codes fall back to all-red so no illegal pair can ever be shown.
  function automatic lamps_t lamps_for(input logic [PHASE_W-1:0] s);
    lamps_t l;
    l.main_l = LAMP_RED;
    l.side_l = LAMP_RED;
    case (s)
      S_MAIN_GRN: l.main_l = LAMP_GREEN;
      S_MAIN_YEL: l.main_l = LAMP_YELLOW;
      S_SIDE_GRN: l.side_l = LAMP_GREEN;
      S_SIDE_YEL: l.side_l = LAMP_YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - loadable down-counting phase timer, saturating at zero
module tl_phase_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - main/side road traffic light FSM with registered lamps
// Optional pedestrian walk phase enabled by defining TRAFFIC_LIGHT_PED_EN.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int GREEN_MAIN_T = 8,
  parameter int GREEN_SIDE_T = 5,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               side_req,
  input  logic               ped_req,
  output logic [0:2]         main_light,
  output logic [0:2]         side_light,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  function automatic bit dur_ok(input int t);
    return (t >= 1) && (longint'(t - 1) <= CNT_MAX);
  endfunction

  if (!(dur_ok(GREEN_MAIN_T) && dur_ok(GREEN_SIDE_T) && dur_ok(YELLOW_T) && dur_ok(ALLRED_T)))
  begin : g_bad_durations
    $error("traffic_light_ctrl: every duration must be >= 1 and T-1 must fit in CNT_W bits");
  end

  function automatic logic [CNT_W-1:0] len_m1(input logic [PHASE_W-1:0] s);
    case (s)
      S_MAIN_GRN: return CNT_W'(GREEN_MAIN_T - 1);
      S_SIDE_GRN: return CNT_W'(GREEN_SIDE_T - 1);
      S_MAIN_YEL,
      S_SIDE_YEL: return CNT_W'(YELLOW_T - 1);
      default:    return CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  logic [PHASE_W-1:0] state, state_nx;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_zero, tmr_load;
  logic               side_pend, req_any, enter_side;
  lamps_t             lamps_nx;

  tl_phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(ALLRED_T - 1))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(len_m1(state_nx)),
    .value   (tmr_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    case (state)
      S_MAIN_GRN: if (tmr_zero && req_any) begin state_nx = S_MAIN_YEL; tmr_load = 1'b1; end
      S_MAIN_YEL: if (tmr_zero) begin state_nx = S_RED1;     tmr_load = 1'b1; end
      S_RED1:     if (tmr_zero) begin state_nx = S_SIDE_GRN; tmr_load = 1'b1; end
      S_SIDE_GRN: if (tmr_zero) begin state_nx = S_SIDE_YEL; tmr_load = 1'b1; end
      S_SIDE_YEL: if (tmr_zero) begin state_nx = S_RED2;     tmr_load = 1'b1; end
      S_RED2:     if (tmr_zero) begin state_nx = S_MAIN_GRN; tmr_load = 1'b1; end
      default: begin
        state_nx = S_RED2;
        tmr_load = 1'b1;
      end
    endcase
  end

  assign enter_side = (state_nx == S_SIDE_GRN) && (state != S_SIDE_GRN);
  assign lamps_nx   = lamps_for(state_nx);
  assign phase      = state;

  // Lamps are decoded from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RED2;
      main_light <= LAMP_RED;
      side_light <= LAMP_RED;
      side_pend  <= 1'b0;
    end else begin
      state      <= state_nx;
      main_light <= lamps_nx.main_l;
      side_light <= lamps_nx.side_l;
      if (enter_side) begin
        side_pend <= 1'b0;
      end else if (side_req) begin
        side_pend <= 1'b1;
      end
    end
  end

`ifdef TRAFFIC_LIGHT_PED_EN
  logic ped_pend;

  assign req_any = side_pend | side_req | ped_pend | ped_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pend <= 1'b0;
      walk     <= 1'b0;
    end else begin
      if (enter_side) begin
        ped_pend <= 1'b0;
      end else if (ped_req) begin
        ped_pend <= 1'b1;
      end
      if (enter_side) begin
        walk <= ped_pend;
      end else if (state_nx != S_SIDE_GRN) begin
        walk <= 1'b0;
      end
    end
  end
`else
  logic unused_ped_req;

  assign req_any        = side_pend | side_req;
  assign walk           = 1'b0;
  assign unused_ped_req = ped_req;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl (honours TRAFFIC_LIGHT_PED_EN)
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [0:2] main_light, side_light;
  logic       walk;
  logic [2:0] phase;

  int vectors = 0;
  int miscompares = 0;

  traffic_light_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .main_light(main_light),
    .side_light(side_light),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
    $fatal(1, "watchdog");
  end

  // Phase order 0..5: main green, main yellow, red1, side green, side yellow, red2.
  logic [2:0] lm  [6] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ls  [6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};
  int         dur [6] = '{8, 3, 2, 5, 3, 2};

  // Reference model: elapsed cycles in the current phase, counted upward.
  int m_phase, m_el;
  bit m_side_pend, m_ped_pend, m_walk;

  function automatic logic [9:0] expv(input int ph, input logic wk);
    return {3'(ph), lm[ph], ls[ph], wk};
  endfunction

  task automatic chk(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = {phase, main_light, side_light, walk};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
               name, $time, got[9:7], got[6:4], got[3:1], got[0], exp[9:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_phase = 5; m_el = 0; m_side_pend = 0; m_ped_pend = 0; m_walk = 0;
  endtask

  task automatic model_tick(input logic sr, input logic pr);
    bit req, leave;
    req = m_side_pend | sr;
`ifdef TRAFFIC_LIGHT_PED_EN
    req = req | m_ped_pend | pr;
`endif
    if (m_phase == 0) leave = (m_el >= dur[0] - 1) && req;
    else              leave = (m_el == dur[m_phase] - 1);
    if (leave && m_phase == 2) begin
`ifdef TRAFFIC_LIGHT_PED_EN
      m_walk = m_ped_pend;
`endif
      m_side_pend = 0;
      m_ped_pend  = 0;
    end else begin
      if (sr) m_side_pend = 1;
`ifdef TRAFFIC_LIGHT_PED_EN
      if (pr) m_ped_pend = 1;
`endif
    end
    if (leave && m_phase == 3) m_walk = 0;
    if (leave) begin
      m_phase = (m_phase + 1) % 6;
      m_el = 0;
    end else if (m_el < 100000) begin
      m_el++;
    end
  endtask

  task automatic step(input logic sr, input logic pr);
    side_req = sr;
    ped_req  = pr;
    @(posedge clk);
    model_tick(sr, pr);
    @(negedge clk);
    chk("model", expv(m_phase, m_walk));
  endtask

  task automatic run_seg(input logic sr, input logic pr, input int n, input int ph, input logic wk);
    for (int i = 0; i < n; i++) begin
      step(sr, pr);
      chk("table", expv(ph, wk));
    end
  endtask

  task automatic do_reset();
    side_req = 0;
    ped_req  = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_state", expv(5, 1'b0));
    rst = 1'b0;
  endtask

  typedef struct {
    logic sr;
    logic pr;
    int   n;
    int   ph;
    logic wk;
  } seg_t;

  function automatic seg_t mk(input logic sr, input logic pr, input int n, input int ph, input logic wk);
    seg_t s;
    s.sr = sr; s.pr = pr; s.n = n; s.ph = ph; s.wk = wk;
    return s;
  endfunction

  seg_t tbl[$];

  initial begin
    // Side request at main-green cycle 2, then a late request after 20 cycles of green.
    tbl.push_back(mk(0, 0, 1, 5, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0, 0));
    tbl.push_back(mk(0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 2, 2, 0));
    tbl.push_back(mk(0, 0, 5, 3, 0));
    tbl.push_back(mk(0, 0, 3, 4, 0));
    tbl.push_back(mk(0, 0, 2, 5, 0));
    tbl.push_back(mk(0, 0, 20, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 2, 2, 0));
    tbl.push_back(mk(0, 0, 5, 3, 0));
    tbl.push_back(mk(0, 0, 3, 4, 0));
    tbl.push_back(mk(0, 0, 2, 5, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0));
`ifdef TRAFFIC_LIGHT_PED_EN
    tbl.push_back(mk(0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 2, 2, 0));
    tbl.push_back(mk(0, 0, 5, 3, 1));
    tbl.push_back(mk(0, 0, 3, 4, 0));
    tbl.push_back(mk(0, 0, 2, 5, 0));
    tbl.push_back(mk(0, 0, 10, 0, 0));
`else
    tbl.push_back(mk(0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 30, 0, 0));
`endif

    model_reset();
    @(negedge clk);

    // No requests: two cycles of red, then main green held.
    do_reset();
    run_seg(0, 0, 1, 5, 0);
    run_seg(0, 0, 100, 0, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      run_seg(tbl[i].sr, tbl[i].pr, tbl[i].n, tbl[i].ph, tbl[i].wk);
    end

    // Asynchronous reset in side green with a request pending.
    do_reset();
    run_seg(1, 0, 1, 5, 0);
    run_seg(0, 0, 8, 0, 0);
    run_seg(0, 0, 3, 1, 0);
    run_seg(0, 0, 2, 2, 0);
    run_seg(0, 0, 1, 3, 0);
    run_seg(1, 0, 1, 3, 0);
    side_req = 0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_immediate", expv(5, 1'b0));
    @(posedge clk);
    @(negedge clk);
    chk("async_rst_held", expv(5, 1'b0));
    rst = 1'b0;
    run_seg(0, 0, 1, 5, 0);
    run_seg(0, 0, 15, 0, 0);

    // Random request traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0));
    end

    // side_req held high: 23-cycle period.
    do_reset();
    run_seg(1, 0, 1, 5, 0);
    for (int k = 0; k < 4; k++) begin
      run_seg(1, 0, 8, 0, 0);
      run_seg(1, 0, 3, 1, 0);
      run_seg(1, 0, 2, 2, 0);
      run_seg(1, 0, 5, 3, 0);
      run_seg(1, 0, 3, 4, 0);
      run_seg(1, 0, 2, 5, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter GREEN_MAIN_T, default 8: minimum main-road green duration, in cycles.
REQ-002 SHALL have parameter GREEN_SIDE_T, default 5: side-road green duration, in cycles.
REQ-003 SHALL have parameter YELLOW_T, default 3: yellow duration for either road, in cycles.
REQ-004 SHALL have parameter ALLRED_T, default 2: all-red clearance duration, in cycles.
REQ-005 SHALL have parameter CNT_W, default 8: phase timer width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port side_req, input, 1: side-road vehicle sensor, level, sampled every cycle.
REQ-009 SHALL have port ped_req, input, 1: pedestrian push-button, level, sampled every cycle.
REQ-010 SHALL have port main_light, output, [0:2]: main-road lamp, registered one-hot.
REQ-011 SHALL have port side_light, output, [0:2]: side-road lamp, registered one-hot.
REQ-012 SHALL have port walk, output, 1: pedestrian walk lamp, registered.
REQ-013 SHALL have port phase, output, [2:0]: current state code, for debug.

Function
REQ-014 SHALL use lamp encodings RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
REQ-015 SHALL implement a 6-state FSM with codes 0-5: MAIN_GRN, MAIN_YEL, RED1, SIDE_GRN, SIDE_YEL, RED2.
REQ-016 SHALL drive lamps per state:
- MAIN_GRN: main GREEN, side RED.
- MAIN_YEL: main YELLOW, side RED.
- SIDE_GRN: main RED, side GREEN.
- SIDE_YEL: main RED, side YELLOW.
- RED1, RED2: both RED.
REQ-017 SHALL load the down-counting timer with T-1 on entry to each state; a state is left only when the timer is 0.
- Every non-MAIN_GRN state therefore lasts exactly T cycles.
REQ-018 SHALL advance MAIN_YEL->RED1->SIDE_GRN->SIDE_YEL->RED2->MAIN_GRN unconditionally on timer expiry.
REQ-019 SHALL leave MAIN_GRN only when the timer is 0 AND a request is pending.
- Otherwise it holds MAIN_GRN indefinitely, with the timer saturated at 0.
REQ-020 SHALL set the side_pend flag on side_req=1 in any state, and clear it on the cycle SIDE_GRN is entered.
- If side_req is asserted on that same cycle, the clear wins.
REQ-021 SHALL treat a request arriving while the timer>0 in MAIN_GRN as pending; the minimum green is still honoured.
REQ-022 SHALL register all outputs, so lamp changes appear on the same edge as the state change.
REQ-023 SHALL present no illegal lamp combination on any cycle; any illegal state code forces RED2 with the timer reloaded.

Reset
REQ-024 SHALL, while rst=1, hold the following values:
- state RED2, timer ALLRED_T-1;
- main_light=side_light=RED, walk=0, phase=5;
- side_pend=ped_pend=0.
REQ-025 SHALL restart from RED2 when rst is asserted mid-phase, discarding pending requests.
- The first MAIN_GRN follows ALLRED_T cycles after deassertion.

Configuration
REQ-026 SHALL gate the pedestrian feature with macro TRAFFIC_LIGHT_PED_EN.
- Defined: ped_req sets ped_pend, which also counts as a pending request for REQ-019; ped_pend clears on SIDE_GRN entry; walk=1 throughout SIDE_GRN when ped_pend was set at entry.
- Undefined: ped_req is ignored, walk is constant 0, and no ped_pend register exists; ports are unchanged.

Structure
REQ-027 SHALL place lamp encodings, state codes and phase width in shared package tl_pkg.
REQ-028 SHALL implement the timer as sub-module tl_phase_timer: load/value/zero, saturating at 0, width CNT_W.
REQ-029 SHALL check at elaboration that every T is >=1 and that every T-1 fits in CNT_W; otherwise elaboration errors.

Verification (GREEN_MAIN_T=8, GREEN_SIDE_T=5, YELLOW_T=3, ALLRED_T=2)
REQ-030 SHALL cover: reset released, no requests -> RED2 for 2 cycles, then MAIN_GRN held for 100 cycles with phase=0.
REQ-031 SHALL cover: side_req pulsed 1 cycle at MAIN_GRN cycle 2 -> main green 8 cycles, yellow 3, red 2, side green 5, side yellow 3, red 2, then main green.
REQ-032 SHALL cover: side_req pulsed after 20 cycles of MAIN_GRN -> MAIN_YEL on the next edge.
REQ-033 SHALL cover (PED_EN defined): ped_req pulsed, no side_req -> full cycle, walk=1 for exactly 5 cycles aligned with side GREEN; (PED_EN undefined): no cycle, walk stays 0.
REQ-034 SHALL cover: rst asserted asynchronously during SIDE_GRN -> both lamps RED immediately, pending cleared, MAIN_GRN 2 cycles after release.
REQ-035 SHALL cover: side_req held high continuously -> repeating 23-cycle period, never a lamp combination other than REQ-016.
